// File: rtl/game_phys_pkg.sv
// Shared fixed-point widths, FSM state codes and helpers for the player physics block.
package game_phys_pkg;

  localparam int FRAC_BITS = 4;
  localparam int ROW_W     = 10;
  localparam int VEL_W     = 12;
  localparam int POS_W     = 1 + ROW_W + FRAC_BITS;

  localparam logic [1:0] GROUNDED = 2'd0;
  localparam logic [1:0] RISING   = 2'd1;
  localparam logic [1:0] FALLING  = 2'd2;

  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic signed [VEL_W-1:0] vel_t;

  function automatic pos_t row_to_pos(input logic [ROW_W-1:0] row);
    return {1'b0, row, {FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/player_jump_physics_if.sv
// Bundle between the VGA timing / input side and the player physics block.
interface player_jump_physics_if;
  import game_phys_pkg::*;

  logic [ROW_W-1:0] hcount;
  logic [ROW_W-1:0] vcount;
  logic             jump_btn;
  logic             enable;
  logic [ROW_W-1:0] player_y;
  logic             airborne;
  logic             land_pulse;
  logic             frame_tick;

  modport master (
    output hcount, vcount, jump_btn, enable,
    input  player_y, airborne, land_pulse, frame_tick
  );

  modport slave (
    input  hcount, vcount, jump_btn, enable,
    output player_y, airborne, land_pulse, frame_tick
  );

endinterface

// File: rtl/player_jump_physics_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button followed by a rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_async,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = btn_async;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rise_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/player_jump_physics.sv
// Player vertical motion: jump on button, Q.4 gravity, updated once per frame in vblank.
module player_jump_physics
  import game_phys_pkg::*;
#(
  parameter logic [ROW_W-1:0] GROUND_Y  = 10'd344,
  parameter logic [ROW_W-1:0] CEIL_Y    = 10'd0,
  parameter logic [VEL_W-1:0] JUMP_VEL  = 12'd160,
  parameter logic [VEL_W-1:0] GRAVITY   = 12'd8,
  parameter logic [VEL_W-1:0] MAX_FALL  = 12'd192,
  parameter logic [ROW_W-1:0] TICK_LINE = 10'd480
) (
  input logic                  pix_clk,
  input logic                  rst_n,
  player_jump_physics_if.slave bus
);

  localparam pos_t GROUND_POS   = row_to_pos(GROUND_Y);
  localparam pos_t CEIL_POS     = row_to_pos(CEIL_Y);
  localparam vel_t LAUNCH_VEL   = vel_t'(12'd0 - JUMP_VEL);
  localparam vel_t GRAV_VEL     = vel_t'(GRAVITY);
  localparam vel_t MAX_FALL_VEL = vel_t'(MAX_FALL);

  logic             btn_edge;
  logic [1:0]       state_q, state_d;
  pos_t             pos_q, pos_d;
  vel_t             vel_q, vel_d;
  logic             pending_q, pending_d;
  logic             frame_tick_q, frame_tick_d;
  logic             land_q, land_d;
  logic [ROW_W-1:0] player_y_q, player_y_d;
  pos_t             vel_ext;
  pos_t             pos_step;
  vel_t             vel_grav;

  btn_sync_edge u_jump_sync (
    .clk        (pix_clk),
    .rst_n      (rst_n),
    .btn_async  (bus.jump_btn),
    .rise_pulse (btn_edge)
  );

  assign vel_ext  = {{(POS_W-VEL_W){vel_q[VEL_W-1]}}, vel_q};
  assign pos_step = pos_q + vel_ext;
  assign vel_grav = vel_q + GRAV_VEL;

  // frame_tick_q marks the tick cycle; an edge arriving in that same cycle still launches.
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    vel_d        = vel_q;
    land_d       = 1'b0;
    pending_d    = pending_q | btn_edge;
    frame_tick_d = (bus.hcount == '0) && (bus.vcount == TICK_LINE);

    if (frame_tick_q) begin
      pending_d = 1'b0;
    end

    if (state_q != GROUNDED && state_q != RISING && state_q != FALLING) begin
      state_d = GROUNDED;
      pos_d   = GROUND_POS;
      vel_d   = '0;
    end else if (frame_tick_q && bus.enable) begin
      case (state_q)
        GROUNDED: begin
          if (pending_q | btn_edge) begin
            vel_d   = LAUNCH_VEL;
            state_d = RISING;
          end
        end
        RISING: begin
          pos_d = pos_step;
          vel_d = vel_grav;
          if (!vel_grav[VEL_W-1]) begin
            state_d = FALLING;
          end
          if (pos_step < CEIL_POS) begin
            pos_d   = CEIL_POS;
            vel_d   = '0;
            state_d = FALLING;
          end
        end
        FALLING: begin
          pos_d = pos_step;
          vel_d = (vel_grav > MAX_FALL_VEL) ? MAX_FALL_VEL : vel_grav;
          if (pos_step >= GROUND_POS) begin
            pos_d   = GROUND_POS;
            vel_d   = '0;
            state_d = GROUNDED;
            land_d  = 1'b1;
          end
        end
        default: state_d = GROUNDED;
      endcase
    end

    player_y_d = pos_d[FRAC_BITS +: ROW_W];
  end

  always_ff @(posedge pix_clk) begin
    if (!rst_n) begin
      state_q      <= GROUNDED;
      pos_q        <= GROUND_POS;
      vel_q        <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      land_q       <= 1'b0;
      player_y_q   <= GROUND_Y;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      vel_q        <= vel_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      land_q       <= land_d;
      player_y_q   <= player_y_d;
    end
  end

  assign bus.player_y   = player_y_q;
  assign bus.airborne   = (state_q == RISING) || (state_q == FALLING);
  assign bus.land_pulse = land_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_player_jump_physics.sv
// Bench for player_jump_physics: free-running compressed VGA timing, per-cycle model compare.
module tb_player_jump_physics;

  localparam int GROUND_POS = 344 * 16;

  logic pix_clk = 1'b0;
  logic rst_n   = 1'b0;

  always #5 pix_clk = ~pix_clk;

  player_jump_physics_if if0 ();
  player_jump_physics_if if1 ();

  player_jump_physics u_dut0 (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .bus     (if0)
  );

  player_jump_physics #(.CEIL_Y(10'd300)) u_dut1 (
    .pix_clk (pix_clk),
    .rst_n   (rst_n),
    .bus     (if1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_count = 0;
  int land_count [2] = '{0, 0};
  int press_seq  [2] = '{0, 0};
  int seen_seq   [2] = '{0, 0};
  int ceil_pos   [2] = '{0, 300 * 16};
  int m_pos [2];
  int m_vel [2];
  bit m_air [2];
  bit m_up  [2];
  bit m_land [2];
  bit m_tick;

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    n_checks++;
    if (actual !== 32'(expected)) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Frame rules applied to one player: launch from ground, rise under gravity, fall and land
  task automatic stepModel(input int d, input bit pend);
    if (!m_air[d]) begin
      if (pend) begin
        m_vel[d] = -160;
        m_air[d] = 1'b1;
        m_up[d]  = 1'b1;
      end
    end else if (m_up[d]) begin
      m_pos[d] = m_pos[d] + m_vel[d];
      m_vel[d] = m_vel[d] + 8;
      if (m_vel[d] >= 0) m_up[d] = 1'b0;
      if (m_pos[d] < ceil_pos[d]) begin
        m_pos[d] = ceil_pos[d];
        m_vel[d] = 0;
        m_up[d]  = 1'b0;
      end
    end else begin
      m_pos[d] = m_pos[d] + m_vel[d];
      m_vel[d] = (m_vel[d] + 8 > 192) ? 192 : m_vel[d] + 8;
      if (m_pos[d] >= GROUND_POS) begin
        m_pos[d]  = GROUND_POS;
        m_vel[d]  = 0;
        m_air[d]  = 1'b0;
        m_land[d] = 1'b1;
      end
    end
  endtask

  // Compressed raster: 8 columns, lines 100/200/479/480/481 so each frame is 40 cycles
  initial begin : timingGen
    logic [9:0] vlist [5];
    int h;
    int vi;
    vlist[0] = 10'd100; vlist[1] = 10'd200; vlist[2] = 10'd479;
    vlist[3] = 10'd480; vlist[4] = 10'd481;
    h  = 0;
    vi = 0;
    if0.hcount = 10'd0; if1.hcount = 10'd0;
    if0.vcount = vlist[0]; if1.vcount = vlist[0];
    forever begin
      @(negedge pix_clk);
      h = (h + 1) % 8;
      if (h == 0) vi = (vi + 1) % 5;
      if0.hcount = 10'(h); if1.hcount = 10'(h);
      if0.vcount = vlist[vi]; if1.vcount = vlist[vi];
    end
  end

  // Model advances on each clock edge, then every output of both players is compared
  initial begin : modelCompare
    logic [9:0] y_s [2];
    logic       a_s [2];
    logic       l_s [2];
    logic       f_s [2];
    logic [9:0] prev_y [2];
    logic       prev_f [2];
    bit         en_s [2];
    bit         pend;
    int         cyc;
    cyc = 0;
    forever begin
      @(posedge pix_clk);
      en_s[0] = if0.enable;
      en_s[1] = if1.enable;
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          m_pos[d] = GROUND_POS; m_vel[d] = 0; m_air[d] = 1'b0;
          m_up[d] = 1'b0; m_land[d] = 1'b0; seen_seq[d] = press_seq[d];
        end
        m_tick = 1'b0;
      end else begin
        for (int d = 0; d < 2; d++) m_land[d] = 1'b0;
        if (m_tick) begin
          tick_count++;
          for (int d = 0; d < 2; d++) begin
            pend = (press_seq[d] != seen_seq[d]);
            seen_seq[d] = press_seq[d];
            if (en_s[d]) stepModel(d, pend);
          end
        end
        m_tick = (if0.hcount == 10'd0) && (if0.vcount == 10'd480);
      end
      #1;
      y_s[0] = if0.player_y;   y_s[1] = if1.player_y;
      a_s[0] = if0.airborne;   a_s[1] = if1.airborne;
      l_s[0] = if0.land_pulse; l_s[1] = if1.land_pulse;
      f_s[0] = if0.frame_tick; f_s[1] = if1.frame_tick;
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("dut%0d.player_y", d), 32'(y_s[d]), m_pos[d] >>> 4);
        checkOutput($sformatf("dut%0d.airborne", d), 32'(a_s[d]), int'(m_air[d]));
        checkOutput($sformatf("dut%0d.land_pulse", d), 32'(l_s[d]), int'(m_land[d]));
        checkOutput($sformatf("dut%0d.frame_tick", d), 32'(f_s[d]), int'(m_tick));
        if (l_s[d] === 1'b1) land_count[d]++;
        if (cyc > 4 && rst_n && y_s[d] !== prev_y[d]) begin
          checkOutput($sformatf("dut%0d.y_change_after_tick", d), 32'(prev_f[d]), 1);
          checkOutput($sformatf("dut%0d.y_change_in_blanking", d),
                      32'(if0.vcount >= 10'd480), 1);
        end
        prev_y[d] = y_s[d];
        prev_f[d] = f_s[d];
      end
      cyc++;
    end
  end

  task automatic waitTicks(input int n);
    int target;
    target = tick_count + n;
    while (tick_count < target) @(negedge pix_clk);
  endtask

  task automatic applyStimulus(input int d);
    if (d == 0) if0.jump_btn = 1'b1;
    else        if1.jump_btn = 1'b1;
    press_seq[d]++;
    repeat (4) @(negedge pix_clk);
    if (d == 0) if0.jump_btn = 1'b0;
    else        if1.jump_btn = 1'b0;
  endtask

  task automatic checkPlayer(input int d, input string tag, input int y, input int air);
    if (d == 0) begin
      checkOutput({tag, ".player_y"}, 32'(if0.player_y), y);
      checkOutput({tag, ".airborne"}, 32'(if0.airborne), air);
    end else begin
      checkOutput({tag, ".player_y"}, 32'(if1.player_y), y);
      checkOutput({tag, ".airborne"}, 32'(if1.airborne), air);
    end
  endtask

  initial begin : stimulus
    int lc;
    if0.jump_btn = 1'b0; if1.jump_btn = 1'b0;
    if0.enable   = 1'b1; if1.enable   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge pix_clk);
    checkPlayer(0, "reset0", 344, 0);
    checkPlayer(1, "reset1", 344, 0);
    checkOutput("reset0.land_pulse", 32'(if0.land_pulse), 0);
    checkOutput("reset0.frame_tick", 32'(if0.frame_tick), 0);
    rst_n = 1'b1;

    // Full jump: launch tick, apex region, touchdown
    waitTicks(1);
    lc = land_count[0];
    applyStimulus(0);
    waitTicks(1);  checkPlayer(0, "jump.t1", 344, 1);
    waitTicks(20); checkPlayer(0, "jump.t21", 239, 1);
    waitTicks(20); checkPlayer(0, "jump.t41", 334, 1);
    waitTicks(1);  checkPlayer(0, "jump.t42", 344, 0);
    checkOutput("jump.land_pulse", 32'(if0.land_pulse), 1);
    waitTicks(2);
    checkOutput("jump.land_count", 32'(land_count[0] - lc), 1);

    // Same jump with extra presses while airborne
    lc = land_count[0];
    applyStimulus(0);
    waitTicks(3);  applyStimulus(0);
    waitTicks(7);  applyStimulus(0);
    waitTicks(11); checkPlayer(0, "dbl.t21", 239, 1);
    applyStimulus(0);
    waitTicks(21); checkPlayer(0, "dbl.t42", 344, 0);
    waitTicks(2);  checkPlayer(0, "dbl.after", 344, 0);
    checkOutput("dbl.land_count", 32'(land_count[0] - lc), 1);

    // Ceiling at row 300
    applyStimulus(1);
    waitTicks(6);  checkPlayer(1, "ceil.t6", 300, 1);
    waitTicks(13); checkPlayer(1, "ceil.t19", 339, 1);
    waitTicks(1);  checkPlayer(1, "ceil.t20", 344, 0);
    checkOutput("ceil.land_pulse", 32'(if1.land_pulse), 1);

    // Freeze mid-flight for 5 frames with a dropped press inside the window
    waitTicks(1);
    applyStimulus(1);
    waitTicks(7);  checkPlayer(1, "hold.t7", 300, 1);
    if1.enable = 1'b0;
    waitTicks(2);  applyStimulus(1);
    waitTicks(3);  checkPlayer(1, "hold.frozen", 300, 1);
    if1.enable = 1'b1;
    waitTicks(12); checkPlayer(1, "hold.resume", 339, 1);
    waitTicks(1);  checkPlayer(1, "hold.land", 344, 0);
    waitTicks(2);  checkPlayer(1, "hold.no_relaunch", 344, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached at t=%0t, expected end of test", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
